// File: rtl/ibuf_pkg.sv
// Types and default latencies shared by the instruction buffer, its
// execute unit and the buffer monitor.
package ibuf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } exec_state_t;

  localparam int DEF_LONG_LAT  = 4;
  localparam int DEF_SHORT_LAT = 1;

  // Wide enough for the largest legal long latency (15).
  localparam int REM_W = 4;

endpackage

// File: rtl/exec_lat_ctr.sv
// Remaining-cycles down-counter for the execute unit: loads a latency on
// accept and counts down once per busy edge, stopping at zero.
module exec_lat_ctr
  import ibuf_pkg::*;
#(
  parameter int W = REM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] rem
);

  logic [W-1:0] rem_q;
  logic [W-1:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load) begin
      rem_d = load_val;
    end else if (dec && (rem_q != '0)) begin
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/ibuf_exec_unit.sv
// Single-slot execute unit fed by the instruction buffer: accepts one
// instruction at a time, holds it for its latency, then pulses retire.
module ibuf_exec_unit
  import ibuf_pkg::*;
#(
  parameter int LONG_LAT  = DEF_LONG_LAT,
  parameter int SHORT_LAT = DEF_SHORT_LAT,
  parameter int INSTR_W   = 32,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [INSTR_W-1:0] issue_instr,
  input  logic               issue_is_long,
  output logic               issue_ready,
  output logic               exec_busy,
  output logic               exec_will_free_next,
  output logic               retire_valid,
  output logic [INSTR_W-1:0] retire_instr,
  output logic [CNT_W-1:0]   retire_count,
  output logic               protocol_err
);

  exec_state_t        state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               retire_valid_q, retire_valid_d;
  logic [INSTR_W-1:0] retire_instr_q, retire_instr_d;
  logic [CNT_W-1:0]   retire_count_q, retire_count_d;
  logic               protocol_err_q, protocol_err_d;

  logic [REM_W-1:0]   rem;
  logic [REM_W-1:0]   rem_load;
  logic               accept;
  logic               rem_dec;

  assign accept   = issue_valid & issue_ready;
  assign rem_load = issue_is_long ? REM_W'(LONG_LAT) : REM_W'(SHORT_LAT);
  assign rem_dec  = exec_busy & ~accept;

  exec_lat_ctr #(
    .W(REM_W)
  ) u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (rem_load),
    .dec      (rem_dec),
    .rem      (rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accept always (re)enters EXEC, even in the last busy cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!accept && exec_will_free_next) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    exec_busy           = (state_q == EXEC);
    exec_will_free_next = exec_busy && (rem == REM_W'(1));
    issue_ready         = ~exec_busy | exec_will_free_next;
  end

  // Datapath: latched word, retire pulse, saturating count, sticky error.
  always_comb begin
    instr_d        = accept ? issue_instr : instr_q;
    retire_valid_d = exec_will_free_next;
    retire_instr_d = exec_will_free_next ? instr_q : retire_instr_q;
    retire_count_d = retire_count_q;
    if (exec_will_free_next && (retire_count_q != {CNT_W{1'b1}})) begin
      retire_count_d = retire_count_q + 1'b1;
    end
    protocol_err_d = protocol_err_q | (issue_valid & ~issue_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_instr_q <= '0;
      retire_count_q <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      instr_q        <= instr_d;
      retire_valid_q <= retire_valid_d;
      retire_instr_q <= retire_instr_d;
      retire_count_q <= retire_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign retire_valid = retire_valid_q;
  assign retire_instr = retire_instr_q;
  assign retire_count = retire_count_q;
  assign protocol_err = protocol_err_q;

endmodule
